clock_and_query_host: RTL and testbench

Host-side initiator for the bit-serial clock-and-query link. It runs a frame counter in lock-step with the device and serializes a memory address onto the device's serial input. It then deserializes the bits the device returns and presents each completed query as a one-cycle response. It also mirrors the device's per-frame instruction-pointer step, so the controller knows how many instructions have executed.

---
 rtl/clock_and_query_host_if.sv | 26 ++
 rtl/clock_and_query_host.sv | 112 +++++++++++
 tb/tb_clock_and_query_host.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_and_query_host_if.sv
// Bundle of request, response and serial link signals for clock_and_query_host.
// The slave modport is the host block itself. The master modport is whoever
// issues queries and plays the device end of the serial link.
interface clock_and_query_host_if #(
   parameter int NSize = 4
);
   logic             req_valid;
   logic [NSize-1:0] req_address;
   logic             req_ready;
   logic             ser_out;
   logic             ser_in;
   logic             rsp_valid;
   logic [NSize-1:0] rsp_data;
   logic [NSize-1:0] rsp_address;
   logic [NSize:0]   steps;

   modport master (
      output req_valid, req_address, ser_in,
      input  req_ready, ser_out, rsp_valid, rsp_data, rsp_address, steps
   );

   modport slave (
      input  req_valid, req_address, ser_in,
      output req_ready, ser_out, rsp_valid, rsp_data, rsp_address, steps
   );
endinterface

// File: rtl/clock_and_query_host.sv
// Host-side initiator for the bit-serial clock-and-query link.
// A frame is NSize+1 cycles long, and the phase counter runs in lock-step with the device.
// Each launched address is shifted out bit by bit while the device's answer is shifted in.
// A completed answer is presented as a one-cycle response.
// Launches happen at the edge leaving phase NSize-1. The address goes out during
// phase NSize and phases 0..NSize-2 of the following frame. The returned bits are
// collected at the edges leaving phases 0..NSize-1.
// The design assumes NSize >= 3.
module clock_and_query_host #(
   parameter int NSize = 4
) (
   input logic                  clock,
   input logic                  reset,
   clock_and_query_host_if.slave bus
);
   localparam int PW = $clog2(NSize + 1);
   localparam logic [PW-1:0] LastPhase   = PW'(NSize);
   localparam logic [PW-1:0] LaunchPhase = PW'(NSize - 1);
   localparam logic [PW-1:0] QuietPhase  = PW'(NSize - 2);

   logic [PW-1:0]    phase;
   logic             pending_valid;
   logic [NSize-1:0] pending_addr;
   logic             frame_active;
   logic [NSize-1:0] frame_addr;
   logic [NSize-2:0] tx_shift;
   logic [NSize-2:0] rx_shift;
   logic             at_launch;
   logic             accept;
   logic             launch_valid;
   logic [NSize-1:0] launch_addr;

   assign at_launch     = (phase == LaunchPhase);
   assign bus.req_ready = !pending_valid;
   assign accept        = bus.req_valid && !pending_valid;
   assign launch_valid  = pending_valid || accept;
   assign launch_addr   = pending_valid ? pending_addr : bus.req_address;

   // Frame phase counter, which mirrors the device's state sequence 0..NSize.
   always_ff @(posedge clock) begin
      if (reset)
         phase <= '0;
      else if (phase == LastPhase)
         phase <= '0;
      else
         phase <= phase + 1'b1;
   end

   // Single-entry request buffer. At the launch edge it always ends up empty:
   // either the parked entry leaves, or a fresh request bypasses it.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending_valid <= 1'b0;
         pending_addr  <= '0;
      end else if (at_launch) begin
         pending_valid <= 1'b0;
      end else if (accept) begin
         pending_valid <= 1'b1;
         pending_addr  <= bus.req_address;
      end
   end

   // Frame launch and serial transmit. addr[0] goes out in phase NSize.
   // The rest follows in phases 0..NSize-2, and the line is quiet in phase NSize-1.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_active <= 1'b0;
         frame_addr   <= '0;
         tx_shift     <= '0;
         bus.ser_out  <= 1'b0;
      end else if (at_launch) begin
         frame_active <= launch_valid;
         frame_addr   <= launch_addr;
         tx_shift     <= launch_addr[NSize-1:1];
         bus.ser_out  <= launch_valid && launch_addr[0];
      end else if (phase == LastPhase || phase < QuietPhase) begin
         bus.ser_out  <= frame_active && tx_shift[0];
         tx_shift     <= tx_shift >> 1;
      end else begin
         bus.ser_out  <= 1'b0;
      end
   end

   // Serial receive and response. The final bit comes straight from ser_in at the
   // launch edge, so the response uses the address of the frame that just ended.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_shift        <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_data    <= '0;
         bus.rsp_address <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;
         if (phase < LaunchPhase)
            rx_shift <= {bus.ser_in, rx_shift[NSize-2:1]};
         if (at_launch && frame_active) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_data    <= {bus.ser_in, rx_shift};
            bus.rsp_address <= frame_addr;
         end
      end
   end

   // Instruction-pointer mirror. It counts every edge that enters phase NSize and
   // wraps naturally.
   always_ff @(posedge clock) begin
      if (reset)
         bus.steps <= '0;
      else if (at_launch)
         bus.steps <= bus.steps + 1'b1;
   end
endmodule

// File: tb/tb_clock_and_query_host.sv
// Self-checking bench for clock_and_query_host with NSize = 4.
// A transaction-level model predicts every output on every cycle.
// Directed literal checks pin down the test-plan scenarios.
module tb_clock_and_query_host;
   logic clock;
   logic reset;
   int   checks_total  = 0;
   int   checks_passed = 0;

   clock_and_query_host_if #(.NSize(4)) bus ();

   clock_and_query_host #(.NSize(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expected);
      checks_total++;
      if (got === expected)
         checks_passed++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, got, expected, $time);
   endtask

   task automatic applyStimulus(input logic rst, input logic valid, input logic [3:0] addr, input logic sin);
      reset           = rst;
      bus.req_valid   = valid;
      bus.req_address = addr;
      bus.ser_in      = sin;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
   endtask

   // Reference model state. cur_t is the cycle index since reset.
   // launch_t and launch_a list the frames that are in flight.
   // hist records ser_in for each cycle.
   int         cur_t     = 0;
   bit         model_ok  = 1'b0;
   bit         m_pend    = 1'b0;
   logic [3:0] m_paddr   = 4'd0;
   int         launch_t[$];
   logic [3:0] launch_a[$];
   logic       hist[4096];
   logic       exp_ser;
   logic       exp_rv;
   logic [3:0] exp_data  = 4'd0;
   logic [3:0] exp_addr  = 4'd0;

   // Compare process. It checks this cycle's outputs against the transaction-level
   // rules, then advances the model by the edge that ends the cycle.
   always @(negedge clock) begin
      if (model_ok) begin
         exp_ser = 1'b0;
         exp_rv  = 1'b0;
         for (int i = 0; i < launch_t.size(); i++) begin
            int         d;
            logic [3:0] a;
            d = cur_t - launch_t[i];
            a = launch_a[i];
            if (d >= 1 && d <= 4)
               exp_ser = a[d-1];
            if (d == 6) begin
               exp_rv   = 1'b1;
               exp_addr = a;
               for (int k = 0; k < 4; k++)
                  exp_data[k] = hist[(launch_t[i] + 2 + k) % 4096];
            end
         end
         checkOutput("model_req_ready", 32'(bus.req_ready), 32'(!m_pend));
         checkOutput("model_ser_out", 32'(bus.ser_out), 32'(exp_ser));
         checkOutput("model_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
         checkOutput("model_rsp_data", 32'(bus.rsp_data), 32'(exp_data));
         checkOutput("model_rsp_address", 32'(bus.rsp_address), 32'(exp_addr));
         checkOutput("model_steps", 32'(bus.steps), 32'(((cur_t + 1) / 5) % 32));
         while (launch_t.size() > 0 && cur_t - launch_t[0] >= 6) begin
            void'(launch_t.pop_front());
            void'(launch_a.pop_front());
         end
      end
      hist[cur_t % 4096] = bus.ser_in;
      if (reset) begin
         cur_t    = 0;
         model_ok = 1'b1;
         m_pend   = 1'b0;
         exp_data = 4'd0;
         exp_addr = 4'd0;
         launch_t.delete();
         launch_a.delete();
      end else if (model_ok) begin
         bit acc;
         acc = bus.req_valid && !m_pend;
         if (cur_t % 5 == 3) begin
            if (m_pend) begin
               launch_t.push_back(cur_t);
               launch_a.push_back(m_paddr);
               m_pend = 1'b0;
            end else if (acc) begin
               launch_t.push_back(cur_t);
               launch_a.push_back(bus.req_address);
            end
         end else if (acc) begin
            m_pend  = 1'b1;
            m_paddr = bus.req_address;
         end
         cur_t++;
      end
   end

   // Directed scenarios first, then randomized traffic.
   initial begin
      logic [3:0] addr_v;
      logic [3:0] got_v;
      logic       sin;

      // Single query, which also covers the bypass launch.
      doReset();
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset_ser_out", 32'(bus.ser_out), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
      checkOutput("reset_rsp_address", 32'(bus.rsp_address), 32'd0);
      checkOutput("reset_steps", 32'(bus.steps), 32'd0);
      addr_v = 4'b1011;
      got_v  = 4'b0110;
      for (int c = 0; c < 12; c++) begin
         if (c >= 4 && c <= 7)
            checkOutput("single_ser_out", 32'(bus.ser_out), 32'(addr_v[c-4]));
         checkOutput("single_rsp_valid", 32'(bus.rsp_valid), 32'(c == 9));
         if (c == 4)
            checkOutput("bypass_req_ready", 32'(bus.req_ready), 32'd1);
         if (c == 9) begin
            checkOutput("single_rsp_data", 32'(bus.rsp_data), 32'b0110);
            checkOutput("single_rsp_address", 32'(bus.rsp_address), 32'b1011);
         end
         sin = 1'b0;
         if (c >= 5 && c <= 8)
            sin = got_v[c-5];
         applyStimulus(1'b0, c == 3, (c == 3) ? addr_v : 4'd0, sin);
      end

      // Back-to-back: request 3 in cycle 0, then request 9 held from cycle 1 until it is taken.
      doReset();
      for (int c = 0; c < 16; c++) begin
         if (c <= 9)
            checkOutput("b2b_req_ready", 32'(bus.req_ready),
                        32'(c == 0 || c == 4 || c == 9));
         checkOutput("b2b_rsp_valid", 32'(bus.rsp_valid), 32'(c == 9 || c == 14));
         if (c == 9)
            checkOutput("b2b_rsp_address_3", 32'(bus.rsp_address), 32'd3);
         if (c == 14)
            checkOutput("b2b_rsp_address_9", 32'(bus.rsp_address), 32'd9);
         if (c == 0)
            applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
         else if (c <= 4)
            applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
         else
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
      end

      // Idle frames.
      doReset();
      for (int c = 0; c < 20; c++) begin
         checkOutput("idle_ser_out", 32'(bus.ser_out), 32'd0);
         checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         if (c == 19)
            checkOutput("idle_steps", 32'(bus.steps), 32'd4);
         applyStimulus(1'b0, 1'b0, 4'd0, 1'($urandom));
      end

      // Reset in the middle of a frame, followed by a fresh query.
      doReset();
      for (int c = 0; c < 7; c++) begin
         checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         applyStimulus(c == 6, c == 3, 4'b1110, 1'b1);
      end
      checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("abort_ser_out", 32'(bus.ser_out), 32'd0);
      checkOutput("abort_rsp_data", 32'(bus.rsp_data), 32'd0);
      checkOutput("abort_rsp_address", 32'(bus.rsp_address), 32'd0);
      checkOutput("abort_steps", 32'(bus.steps), 32'd0);
      addr_v = 4'b0101;
      got_v  = 4'b1001;
      for (int c = 0; c < 12; c++) begin
         checkOutput("fresh_rsp_valid", 32'(bus.rsp_valid), 32'(c == 9));
         if (c == 9) begin
            checkOutput("fresh_rsp_data", 32'(bus.rsp_data), 32'b1001);
            checkOutput("fresh_rsp_address", 32'(bus.rsp_address), 32'b0101);
         end
         sin = 1'b0;
         if (c >= 5 && c <= 8)
            sin = got_v[c-5];
         applyStimulus(1'b0, c == 3, (c == 3) ? addr_v : 4'd0, sin);
      end

      // Steps wrap across 32 frames with random traffic.
      doReset();
      for (int c = 0; c < 170; c++) begin
         if (c == 158)
            checkOutput("wrap_steps_31", 32'(bus.steps), 32'd31);
         if (c == 159)
            checkOutput("wrap_steps_0", 32'(bus.steps), 32'd0);
         applyStimulus(1'b0, $urandom_range(0, 2) == 0, 4'($urandom), 1'($urandom));
      end

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 700; c++)
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 0,
                       4'($urandom), 1'($urandom));

      @(negedge clock);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
